// File: rtl/result_tx_streamer.sv
// Streams INT32 results from the output BRAM as a framed, little-endian byte stream.
// Define RESULT_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module result_tx_streamer #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W:0]   cfg_word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       bytes_sent
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, HDR2, RD, LAT, SEND,
`ifdef RESULT_TX_CHECKSUM_EN
    CSUM,
`endif
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic              mem_rd_en_d;
  logic [ADDR_W-1:0] mem_rd_addr_d;
  logic [7:0]        out_data_d;
  logic              out_valid_d;
  logic              busy_d;
  logic              done_d;
  logic [31:0]       bytes_sent_d;
  logic              xfer;
  logic              to_tail;
  logic [15:0]       count16;
`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d, csum_x;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bytes_sent  <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      mem_rd_en   <= mem_rd_en_d;
      mem_rd_addr <= mem_rd_addr_d;
      out_data    <= out_data_d;
      out_valid   <= out_valid_d;
      busy        <= busy_d;
      done        <= done_d;
      bytes_sent  <= bytes_sent_d;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    mem_rd_en_d   = 1'b0;
    mem_rd_addr_d = mem_rd_addr;
    out_data_d    = out_data;
    out_valid_d   = out_valid;
    busy_d        = busy;
    done_d        = 1'b0;
    bytes_sent_d  = bytes_sent;
    xfer          = out_valid && out_ready;
    to_tail       = 1'b0;
    count16       = 16'(rem_q);
`ifdef RESULT_TX_CHECKSUM_EN
    csum_d        = csum_q;
    csum_x        = csum_q ^ out_data;
`endif

    if (xfer) bytes_sent_d = bytes_sent + 32'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = HDR0;
          addr_d       = cfg_base_addr;
          rem_d        = (cfg_word_count > MAX_WORDS) ? MAX_WORDS : cfg_word_count;
          bytes_sent_d = '0;
          busy_d       = 1'b1;
          out_valid_d  = 1'b1;
          out_data_d   = HDR_BYTE;
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      HDR0: begin
        if (xfer) begin
          state_d    = HDR1;
          out_data_d = count16[7:0];
        end
      end
      HDR1: begin
        if (xfer) begin
          state_d    = HDR2;
          out_data_d = count16[15:8];
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d     = csum_x;
`endif
        end
      end
      HDR2: begin
        if (xfer) begin
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d = csum_x;
`endif
          if (rem_q != '0) begin
            state_d       = RD;
            out_valid_d   = 1'b0;
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = addr_q;
          end else begin
            to_tail = 1'b1;
          end
        end
      end
      RD: state_d = LAT;
      LAT: begin
        state_d     = SEND;
        shift_d     = mem_rd_data;
        out_data_d  = mem_rd_data[7:0];
        out_valid_d = 1'b1;
        idx_d       = '0;
      end
      SEND: begin
        if (xfer) begin
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d = csum_x;
`endif
          if (idx_q != 2'd3) begin
            idx_d      = idx_q + 2'd1;
            shift_d    = shift_q >> 8;
            out_data_d = shift_q[15:8];
          end else begin
            rem_d  = rem_q - CNT_W'(1);
            addr_d = addr_q + ADDR_W'(1);
            if (rem_q != CNT_W'(1)) begin
              state_d       = RD;
              out_valid_d   = 1'b0;
              mem_rd_en_d   = 1'b1;
              mem_rd_addr_d = addr_q + ADDR_W'(1);
            end else begin
              to_tail = 1'b1;
            end
          end
        end
      end
`ifdef RESULT_TX_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          state_d     = FIN;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end
      end
`endif
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Last data/header byte accepted: checksum byte or straight to done
    if (to_tail) begin
`ifdef RESULT_TX_CHECKSUM_EN
      state_d     = CSUM;
      out_valid_d = 1'b1;
      out_data_d  = csum_x;
`else
      state_d     = FIN;
      out_valid_d = 1'b0;
      done_d      = 1'b1;
      busy_d      = 1'b0;
`endif
    end
  end

endmodule
